elevator_controller: RTL

ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/elevator_dir_sel.sv | 51 +++++
 rtl/elevator_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Elevator controller shared types.
// Floor count, widths, state and direction encodings.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_DOOR   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

endpackage

// File: rtl/elevator_dir_sel.sv
// Next travel direction from outstanding calls.
// SCAN while committed; nearest call (ties go up) when free.
module elevator_dir_sel
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  input  dir_e                  cur_dir,
  output dir_e                  next_dir
);

  logic above;
  logic below;
  dir_e near;

  // any call strictly above / below the reference floor
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && i > int'(floor)) above = 1'b1;
      if (pending[i] && i < int'(floor)) below = 1'b1;
    end
  end

  // nearest call; smaller distance overwrites, up overwrites down
  always_comb begin
    near = DIR_NONE;
    for (int d = NUM_FLOORS - 1; d >= 1; d--) begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (pending[i] && i == int'(floor) - d) near = DIR_DOWN;
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (pending[i] && i == int'(floor) + d) near = DIR_UP;
      end
    end
  end

  // keep going while calls lie ahead, else reverse, else stop
  always_comb begin
    next_dir = DIR_NONE;
    unique case (cur_dir)
      DIR_UP:   next_dir = above ? DIR_UP
                         : (below ? DIR_DOWN : DIR_NONE);
      DIR_DOWN: next_dir = below ? DIR_DOWN
                         : (above ? DIR_UP : DIR_NONE);
      default:  next_dir = near;
    endcase
  end

endmodule

// File: rtl/elevator_controller.sv
// Collective (SCAN) elevator controller, 8 floors.
// One shared timer serves both travel and door hold.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 150_000_000
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  overload,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES)
                         ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TMR_W = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_CYCLES);
  localparam logic [TMR_W-1:0] DOOR_LD   = TMR_W'(DOOR_CYCLES);
  localparam logic [TMR_W-1:0] T_ONE     = TMR_W'(1);
  localparam logic [FLOOR_W-1:0] TOP     = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = NUM_FLOORS'(1);

  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;

  logic                    step;
  logic [FLOOR_W-1:0]      arr_floor;
  logic [FLOOR_W-1:0]      sel_floor;
  logic [NUM_FLOORS-1:0]   here;
  logic [NUM_FLOORS-1:0]   req_mask;
  logic [NUM_FLOORS-1:0]   clr;
  dir_e                    nxt_dir;

  // floor reached on this edge; saturates at the shaft ends
  always_comb begin
    step      = (state_q == ST_MOVING) && (tmr_q <= T_ONE);
    arr_floor = floor_q;
    if (dir_q == DIR_UP && floor_q != TOP)
      arr_floor = floor_q + 1'b1;
    else if (dir_q == DIR_DOWN && floor_q != '0)
      arr_floor = floor_q - 1'b1;
    sel_floor = step ? arr_floor : floor_q;
    here      = ONE_HOT0 << sel_floor;
    req_mask  = (state_q == ST_MOVING) ? '0 : (ONE_HOT0 << floor_q);
  end

  elevator_dir_sel u_dir_sel (
    .pending  (pend_q & ~here),
    .floor    (sel_floor),
    .cur_dir  (dir_q),
    .next_dir (nxt_dir)
  );

  // next-state, timer and floor/direction decisions
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    tmr_d   = tmr_q;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        dir_d = DIR_NONE;
        tmr_d = '0;
        if (call_req[floor_q] || pend_q[floor_q]) begin
          state_d = ST_DOOR;
          tmr_d   = DOOR_LD;
          clr     = here;
        end else if (nxt_dir != DIR_NONE) begin
          state_d = ST_MOVING;
          tmr_d   = TRAVEL_LD;
          dir_d   = nxt_dir;
        end
      end
      ST_MOVING: begin
        if (!step) begin
          tmr_d = tmr_q - T_ONE;
        end else begin
          floor_d = arr_floor;
          dir_d   = nxt_dir;
          if (pend_q[arr_floor]) begin
            state_d = ST_DOOR;
            tmr_d   = DOOR_LD;
            clr     = here;
          end else if (nxt_dir != DIR_NONE) begin
            tmr_d = TRAVEL_LD;
          end else begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end
        end
      end
      ST_DOOR: begin
        dir_d = nxt_dir;
        if (overload || call_req[floor_q]) begin
          tmr_d = DOOR_LD;
        end else if (tmr_q > T_ONE) begin
          tmr_d = tmr_q - T_ONE;
        end else if (nxt_dir != DIR_NONE) begin
          state_d = ST_MOVING;
          tmr_d   = TRAVEL_LD;
        end else begin
          state_d = ST_IDLE;
          tmr_d   = '0;
          dir_d   = DIR_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dir_d   = DIR_NONE;
        tmr_d   = '0;
      end
    endcase
    pend_d = (pend_q | (call_req & ~req_mask)) & ~clr;
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      floor_q <= '0;
      pend_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      tmr_q   <= tmr_d;
    end
  end

  assign floor     = floor_q;
  assign pending   = pend_q;
  assign dir_up    = (dir_q == DIR_UP);
  assign dir_down  = (dir_q == DIR_DOWN);
  assign moving    = (state_q == ST_MOVING);
  assign door_open = (state_q == ST_DOOR);

endmodule
